// File: rtl/sort_cas_scheduler.sv
// Block sorter: loads NUM_ELEM words, bubble-sorts them through an external compare-and-swap unit, then streams them out.
// Optional build macro SORT_EARLY_EXIT_EN ends SORT after the first pass that performs no swap.
module sort_cas_scheduler #(
    parameter int SIZE_DATA = 16,
    parameter int NUM_ELEM  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [SIZE_DATA-1:0] i_in_data,
    output logic [SIZE_DATA-1:0] o_cas_a,
    output logic [SIZE_DATA-1:0] o_cas_b,
    input  logic [SIZE_DATA-1:0] i_cas_max,
    input  logic [SIZE_DATA-1:0] i_cas_min,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [SIZE_DATA-1:0] o_out_data,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int IDX_W = $clog2(NUM_ELEM);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);
    localparam logic [IDX_W-1:0] LAST_CMP = IDX_W'(NUM_ELEM - 2);

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    state_t               state, state_nxt;
    logic [SIZE_DATA-1:0] mem [NUM_ELEM];
    logic [IDX_W-1:0]     wr_idx, j, pass, rd_idx;
    logic [IDX_W-1:0]     last, j_hi;
    logic                 done;
    logic                 in_fire, out_fire, pass_end, sort_exit;

    assign last     = LAST_CMP - pass;
    assign j_hi     = j + ONE;
    assign pass_end = (j == last);
    assign in_fire  = i_in_valid && (state == LOAD);
    assign out_fire = i_out_ready && (state == DRAIN);

`ifdef SORT_EARLY_EXIT_EN
    logic swap_flag;
    logic swap_this;

    // Min differing from the lower operand means the pair was out of order; ties never count.
    assign swap_this = (i_cas_min != mem[j]);
    assign sort_exit = pass_end && ((last == '0) || !(swap_flag || swap_this));
`else
    assign sort_exit = pass_end && (last == '0);
`endif

    always_comb begin
        state_nxt   = state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b0;
        case (state)
            LOAD: begin
                o_in_ready = 1'b1;
                if (i_in_valid && (wr_idx == LAST_IDX)) state_nxt = SORT;
            end
            SORT: begin
                o_busy = 1'b1;
                if (sort_exit) state_nxt = DRAIN;
            end
            DRAIN: begin
                o_out_valid = 1'b1;
                if (i_out_ready && (rd_idx == LAST_IDX)) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= LOAD;
            wr_idx <= '0;
            j      <= '0;
            pass   <= '0;
            rd_idx <= '0;
            done   <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
            swap_flag <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        if (wr_idx == LAST_IDX) begin
                            wr_idx <= '0;
                            j      <= '0;
                            pass   <= '0;
`ifdef SORT_EARLY_EXIT_EN
                            swap_flag <= 1'b0;
`endif
                        end else begin
                            wr_idx <= wr_idx + ONE;
                        end
                    end
                end
                SORT: begin
                    if (pass_end) begin
                        j    <= '0;
                        pass <= sort_exit ? '0 : pass + ONE;
`ifdef SORT_EARLY_EXIT_EN
                        swap_flag <= 1'b0;
`endif
                    end else begin
                        j <= j + ONE;
`ifdef SORT_EARLY_EXIT_EN
                        swap_flag <= swap_flag || swap_this;
`endif
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (rd_idx == LAST_IDX) begin
                            rd_idx <= '0;
                            done   <= 1'b1;
                        end else begin
                            rd_idx <= rd_idx + ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Word storage carries no reset; only control state is cleared.
    always_ff @(posedge i_clk) begin
        if (in_fire) begin
            mem[wr_idx] <= i_in_data;
        end else if (state == SORT) begin
            mem[j]    <= i_cas_min;
            mem[j_hi] <= i_cas_max;
        end
    end

    assign o_cas_a    = (state == SORT) ? mem[j]    : mem[0];
    assign o_cas_b    = (state == SORT) ? mem[j_hi] : mem[1];
    assign o_out_data = mem[rd_idx];
    assign o_done     = done;

endmodule

// File: doc/sort_cas_scheduler.md
Name: sort_cas_scheduler

Overview:
- Sequencer that time-shares one external compare-and-swap datapath (comparator + SWAP_unit) to sort a block of NUM_ELEM words.
- Accepts words over a valid/ready input stream into an internal register array.
- Sorts ascending with sequential bubble passes, one compare-swap per cycle.
- Streams the result over a valid/ready output. Sits between the input FIFO and the output formatter in the sort pipeline.

Parameters:
SIZE_DATA, 16, width of each data word
NUM_ELEM, 8, words per sort block (>=2); index width is the derived localparam IDX_W = $clog2(NUM_ELEM)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_in_valid  in  1  input word valid
o_in_ready  out  1  block accepts an input word
i_in_data  in  SIZE_DATA  input word
o_cas_a  out  SIZE_DATA  lower-index operand to the CAS datapath (mem[j])
o_cas_b  out  SIZE_DATA  higher-index operand to the CAS datapath (mem[j+1])
i_cas_max  in  SIZE_DATA  CAS result max, combinational same cycle
i_cas_min  in  SIZE_DATA  CAS result min, combinational same cycle
o_out_valid  out  1  output word valid
i_out_ready  in  1  downstream accepts an output word
o_out_data  out  SIZE_DATA  sorted output word
o_busy  out  1  high while in SORT
o_done  out  1  one-cycle pulse after the last output beat

Behaviour:
- One clock i_clk. Reset i_rst is synchronous and active-high.
- Reset:
  - State=LOAD. All counters (wr_idx, j, pass, rd_idx) are 0. Swap flag is 0.
  - o_in_ready=1, o_out_valid=0, o_busy=0, o_done=0.
  - The register array is not cleared.
- LOAD:
  - o_in_ready=1.
  - On i_in_valid & o_in_ready: mem[wr_idx] <= i_in_data and wr_idx increments.
  - When the beat at wr_idx==NUM_ELEM-1 is accepted: wr_idx <= 0, j <= 0, pass <= 0, next state SORT.
  - o_in_ready is 0 in every other state; i_in_valid is ignored there.
- SORT:
  - o_busy=1. o_cas_a=mem[j], o_cas_b=mem[j+1].
  - Each cycle: mem[j] <= i_cas_min and mem[j+1] <= i_cas_max.
  - last = NUM_ELEM-2-pass.
  - If j<last: j++.
  - If j==last: j <= 0 and pass++. If last==0, next state DRAIN.
  - Fixed SORT duration without the optional feature: NUM_ELEM*(NUM_ELEM-1)/2 cycles (28 for NUM_ELEM=8).
  - Outside SORT, o_cas_a/o_cas_b hold mem[0]/mem[1] and CAS results are ignored.
- Swap detection:
  - swap_this_cycle = (i_cas_min != mem[j]).
  - Equal operands never count as a swap.
  - Swap flag is cleared at each pass start (OR-accumulated over the pass).
- DRAIN:
  - o_out_valid=1, o_out_data=mem[rd_idx].
  - On i_out_ready: rd_idx++.
  - Data is held stable while i_out_ready=0.
  - On acceptance of beat rd_idx==NUM_ELEM-1: rd_idx <= 0, o_done=1 for the next cycle, next state LOAD.
  - LOAD may accept input in the same cycle o_done is high.
- Order and stability: ascending order, index 0 is the smallest. Duplicates are preserved, so the output multiset equals the input multiset.
- Reset mid-operation: i_rst in any state returns to the reset values on the next edge. A partial block is discarded and no o_done is issued.
- No combinational path from i_out_ready to o_out_valid. o_in_ready depends only on state.

Optional Feature:
SORT_EARLY_EXIT_EN
- Defined:
  - At the end of any pass (j==last) with swap flag==0 (including swap_this_cycle), go to DRAIN immediately.
  - Minimum SORT time is NUM_ELEM-1 cycles, for already-sorted input.
  - The normal exit at last==0 still applies.
- Undefined: the swap flag is not used and SORT always runs the full NUM_ELEM*(NUM_ELEM-1)/2 cycles.
- Output data is identical in both builds.

Test Plan:
- NUM_ELEM=8, load 5,3,8,1,9,2,7,4 with i_out_ready=1 -> outputs 1,2,3,4,5,7,8,9; o_busy high exactly 28 cycles (macro off); o_done pulses once after beat 8.
- Load already-sorted 1..8 with SORT_EARLY_EXIT_EN -> o_busy high exactly 7 cycles, output 1..8. Macro off -> 28 cycles, same output.
- Load 6,6,2,6,2,0,0,6; toggle i_out_ready 1,0,0,1 repeating -> output 0,0,2,2,6,6,6,6; o_out_data stable while ready=0; no beat lost or duplicated.
- Assert i_rst for 1 cycle at SORT cycle 10 -> next cycle state LOAD, o_busy=0, o_in_ready=1, no o_done. A new block 8..1 then sorts to 1..8.
- Hold i_in_valid=1 during SORT/DRAIN with data 0xFFFF -> never captured, o_in_ready=0; back-to-back second block accepted in the o_done cycle.
- NUM_ELEM=2, load 0x0009,0x0003 -> SORT lasts 1 cycle, output 0x0003,0x0009.
